bht_branch_predictor: RTL

//  Parametrised branch history table (BHT) of saturating counters for the 5-stage pipeline.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_sat_counter.sv | 38 +++
 rtl/bht_branch_predictor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bp_pkg
// Purpose : Shared PC-source encodings and saturating step helper for the BHT.
// Rev     : 1.0
// ============================================================================
package bp_pkg;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_TGT = 2'b01;
    localparam logic [1:0] PCSRC_RBK = 2'b10;

    // Fixed working width so one helper serves every counter width up to 32.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] ctr,
        input logic             up,
        input logic [SAT_W-1:0] max
    );
        logic [SAT_W-1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != max) res = ctr + SAT_W'(1);
        end else begin
            if (ctr != '0) res = ctr - SAT_W'(1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : bp_sat_counter
// Purpose : CTR_W-bit saturating up/down counter, async reset to CTR_INIT.
// Rev     : 1.0
// ============================================================================
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int              CTR_W    = 2,
    parameter logic [CTR_W-1:0] CTR_INIT = {CTR_W{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [CTR_W-1:0] ctr_o
);

    localparam logic [SAT_W-1:0] CTR_MAX = SAT_W'({CTR_W{1'b1}});

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (en_i) ctr_d = CTR_W'(sat_step(SAT_W'(ctr_q), up_i, CTR_MAX));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctr_q <= CTR_INIT;
        else       ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;

endmodule
`default_nettype wire

// File: rtl/bht_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : bht_branch_predictor
// Purpose : BHT of saturating counters; predicts in ID, trains from EX.
//           Optional gshare indexing when BHT_GSHARE_EN is defined.
// Rev     : 1.0
// ============================================================================
module bht_branch_predictor
    import bp_pkg::*;
#(
    parameter int               PC_W     = 32,
    parameter int               ENTRIES  = 64,
    parameter int               IDX_W    = $clog2(ENTRIES),
    parameter int               CTR_W    = 2,
    parameter logic [CTR_W-1:0] CTR_INIT = {CTR_W{1'b1}},
    parameter int               PERF_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_branch_i,
    input  logic [PC_W-1:0]   id_pc_i,
    output logic              id_taken_o,
    output logic [IDX_W-1:0]  id_idx_o,
    input  logic              ex_branch_i,
    input  logic [IDX_W-1:0]  ex_idx_i,
    input  logic              ex_pred_taken_i,
    input  logic              ex_taken_i,
    output logic              mispredict_o,
    output logic [1:0]        pcsrc_o,
    output logic              id_flush_o,
    output logic [PERF_W-1:0] br_cnt_o,
    output logic [PERF_W-1:0] miss_cnt_o
);

    localparam logic [SAT_W-1:0] PERF_MAX = SAT_W'({PERF_W{1'b1}});

    logic [IDX_W-1:0] pc_idx;
    logic             unused_pc;

    assign pc_idx    = id_pc_i[IDX_W+1:2];
    assign unused_pc = ^{id_pc_i[PC_W-1:IDX_W+2], id_pc_i[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;
    logic [IDX_W-1:0] ghr_shift;

    if (IDX_W == 1) begin : g_ghr_1b
        assign ghr_shift = ex_taken_i;
    end else begin : g_ghr_nb
        assign ghr_shift = {ghr_q[IDX_W-2:0], ex_taken_i};
    end

    always_comb begin
        ghr_d = ghr_q;
        if (ex_branch_i) ghr_d = ghr_shift;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign id_idx_o = pc_idx ^ ghr_q;
`else
    assign id_idx_o = pc_idx;
`endif

    logic [CTR_W-1:0] ctr_tbl [ENTRIES];
    logic [CTR_W-1:0] id_ctr;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bp_sat_counter #(
            .CTR_W    (CTR_W),
            .CTR_INIT (CTR_INIT)
        ) u_ctr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (ex_branch_i && (ex_idx_i == IDX_W'(i))),
            .up_i  (ex_taken_i),
            .ctr_o (ctr_tbl[i])
        );
    end

    // Registered table gives the pre-update value on a same-cycle read/write.
    assign id_ctr     = ctr_tbl[id_idx_o];
    assign id_taken_o = id_ctr[CTR_W-1];

    if (CTR_W > 1) begin : g_ctr_lsb_sink
        logic unused_ctr_lsbs;
        assign unused_ctr_lsbs = ^id_ctr[CTR_W-2:0];
    end

    assign mispredict_o = ex_branch_i & (ex_taken_i != ex_pred_taken_i);

    always_comb begin
        pcsrc_o    = PCSRC_PC4;
        id_flush_o = 1'b0;
        if (mispredict_o) begin
            pcsrc_o    = PCSRC_RBK;
            id_flush_o = 1'b1;
        end else if (id_branch_i && id_taken_o) begin
            pcsrc_o    = PCSRC_TGT;
            id_flush_o = 1'b1;
        end
    end

    logic [PERF_W-1:0] br_cnt_q;
    logic [PERF_W-1:0] br_cnt_d;
    logic [PERF_W-1:0] miss_cnt_q;
    logic [PERF_W-1:0] miss_cnt_d;

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (ex_branch_i)  br_cnt_d   = PERF_W'(sat_step(SAT_W'(br_cnt_q), 1'b1, PERF_MAX));
        if (mispredict_o) miss_cnt_d = PERF_W'(sat_step(SAT_W'(miss_cnt_q), 1'b1, PERF_MAX));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt_o   = br_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule
`default_nettype wire
